// File: rtl/vpm_pkg.sv
// vpm_pkg: shared definitions for video_pattern_mux.
// Holds the mode encodings, the eight colour-bar constants (RGB565) and
// the RGB565 -> RGB888 zero-padding expansion.
package vpm_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_GRID  = 2'd2,
    MODE_SOLID = 2'd3
  } vpm_mode_e;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  // Colour of bar number idx, left (0) to right (7).
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

  // Low bits are zero-padded, not replicated, so FFFF maps to F8FCF8.
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
    return {p[15:11], 3'b000, p[10:5], 2'b00, p[4:0], 3'b000};
  endfunction

endpackage

// File: rtl/vpm_pos_counter.sv
// vpm_pos_counter: DE/VS edge detection and pixel position tracking.
// x counts active pixels within a line, y counts lines within a frame,
// bar_cnt/bar_idx split the line into eight equal bars without a divider.
// With VPM_MOVING_BAR_EN defined the raw x position is exported as well.
module vpm_pos_counter #(
  parameter int H_RES     = 1280,
  parameter int V_RES     = 720,
  parameter int GRID_LOG2 = 5,
  parameter int XW        = $clog2(H_RES),
  parameter int YW        = $clog2(V_RES)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_active,
  input  logic          i_vsync,
`ifdef VPM_MOVING_BAR_EN
  output logic [XW-1:0] o_x,
`endif
  output logic          o_grid_hit,
  output logic [2:0]    o_bar_idx,
  output logic          o_vs_rise
);

  localparam logic [XW-1:0] X_LAST   = XW'(H_RES - 1);
  localparam logic [XW-1:0] BAR_LAST = XW'(H_RES / 8 - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_RES - 1);

  logic          act_dly_q, act_dly_d;
  logic          vs_dly_q, vs_dly_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [XW-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic          act_fall;
  logic          vs_rise;

  // Next-state for the edge detectors and all position counters.
  always_comb begin
    act_fall  = act_dly_q & ~i_active;
    vs_rise   = i_vsync & ~vs_dly_q;
    act_dly_d = i_active;
    vs_dly_d  = i_vsync;
    x_d       = x_q;
    y_d       = y_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;

    if (act_fall) begin
      x_d       = '0;
      bar_cnt_d = '0;
      bar_idx_d = '0;
    end else if (i_active) begin
      if (x_q != X_LAST) x_d = x_q + 1'b1;
      if (bar_cnt_q == BAR_LAST) begin
        bar_cnt_d = '0;
        if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + 1'b1;
      end
    end

    // A vsync edge landing on the same cycle as a DE fall restarts the frame.
    if (vs_rise) begin
      y_d = '0;
    end else if (act_fall && (y_q != Y_LAST)) begin
      y_d = y_q + 1'b1;
    end
  end

  // Counter and edge-detector state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      act_dly_q <= 1'b0;
      vs_dly_q  <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
    end else begin
      act_dly_q <= act_dly_d;
      vs_dly_q  <= vs_dly_d;
      x_q       <= x_d;
      y_q       <= y_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
    end
  end

`ifdef VPM_MOVING_BAR_EN
  assign o_x = x_q;
`endif
  assign o_grid_hit = (x_q[GRID_LOG2-1:0] == '0) || (y_q[GRID_LOG2-1:0] == '0);
  assign o_bar_idx  = bar_idx_q;
  assign o_vs_rise  = vs_rise;

endmodule

// File: rtl/video_pattern_mux.sv
// video_pattern_mux: selects framebuffer pass-through or a built-in test
// pattern (colour bars, grid, solid), expands RGB565 to RGB888 and delays
// DE/HS/VS by one cycle to stay aligned. Colour bars are forced while the
// PSRAM is uncalibrated. Optional macro VPM_MOVING_BAR_EN adds a white
// 8-pixel bar that steps right by 4 pixels every frame in pattern modes.
module video_pattern_mux
  import vpm_pkg::*;
#(
  parameter int H_RES     = 1280,
  parameter int V_RES     = 720,
  parameter int GRID_LOG2 = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_rgb565,
  input  logic        i_active,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_fb_ready,
  input  logic [1:0]  i_pattern_sel,
  input  logic [15:0] i_solid_rgb565,
  output logic [23:0] o_rgb888,
  output logic        o_active,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_pattern_active
);

  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);

  logic        grid_hit;
  logic [2:0]  bar_idx;
  logic        vs_rise;

  vpm_mode_e   mode_q, mode_d;
  vpm_mode_e   eff_mode;
  logic [15:0] pix_565;

  logic [23:0] rgb_q, rgb_d;
  logic        act_q, act_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        pat_q, pat_d;

`ifdef VPM_MOVING_BAR_EN
  logic [XW-1:0] x_pos;
  logic [10:0]   bar_ofs_q, bar_ofs_d;
  logic [11:0]   x_ext, ofs_ext;
  logic          bar_hit;
`endif

  vpm_pos_counter #(
    .H_RES     (H_RES),
    .V_RES     (V_RES),
    .GRID_LOG2 (GRID_LOG2),
    .XW        (XW),
    .YW        (YW)
  ) u_pos (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_active   (i_active),
    .i_vsync    (i_vsync),
`ifdef VPM_MOVING_BAR_EN
    .o_x        (x_pos),
`endif
    .o_grid_hit (grid_hit),
    .o_bar_idx  (bar_idx),
    .o_vs_rise  (vs_rise)
  );

  // Mode selection: latch at vsync; losing calibration drops straight to
  // bars and stays there until a vsync sees the PSRAM ready again.
  always_comb begin
    mode_d = mode_q;
    if (vs_rise) begin
      mode_d = i_fb_ready ? vpm_mode_e'(i_pattern_sel) : MODE_BARS;
    end else if (!i_fb_ready) begin
      mode_d = MODE_BARS;
    end
    eff_mode = i_fb_ready ? mode_q : MODE_BARS;
  end

  // Mode register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) mode_q <= MODE_BARS;
    else       mode_q <= mode_d;
  end

`ifdef VPM_MOVING_BAR_EN
  // Moving-bar offset: steps by 4 each frame, wraps before running off the line.
  always_comb begin
    x_ext     = 12'(x_pos);
    ofs_ext   = {1'b0, bar_ofs_q};
    bar_hit   = (x_ext >= ofs_ext) && (x_ext <= ofs_ext + 12'd7);
    bar_ofs_d = bar_ofs_q;
    if (vs_rise) begin
      if (ofs_ext + 12'd4 >= 12'(H_RES)) bar_ofs_d = '0;
      else                               bar_ofs_d = bar_ofs_q + 11'd4;
    end
  end

  // Moving-bar offset register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) bar_ofs_q <= '0;
    else       bar_ofs_q <= bar_ofs_d;
  end
`endif

  // Pixel mux, blanking and expansion for the output stage.
  always_comb begin
    case (eff_mode)
      MODE_PASS:  pix_565 = i_rgb565;
      MODE_BARS:  pix_565 = bar_color(bar_idx);
      MODE_GRID:  pix_565 = grid_hit ? BAR_WHITE : BAR_BLACK;
      MODE_SOLID: pix_565 = i_solid_rgb565;
      default:    pix_565 = BAR_BLACK;
    endcase
`ifdef VPM_MOVING_BAR_EN
    if ((eff_mode != MODE_PASS) && bar_hit) pix_565 = BAR_WHITE;
`endif
    if (!i_active) pix_565 = BAR_BLACK;
    rgb_d = rgb565_to_888(pix_565);
    act_d = i_active;
    hs_d  = i_hsync;
    vs_d  = i_vsync;
    pat_d = (eff_mode != MODE_PASS);
  end

  // Output registers: every output is exactly one cycle behind its inputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rgb_q <= '0;
      act_q <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      pat_q <= 1'b1;
    end else begin
      rgb_q <= rgb_d;
      act_q <= act_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      pat_q <= pat_d;
    end
  end

  assign o_rgb888         = rgb_q;
  assign o_active         = act_q;
  assign o_hsync          = hs_q;
  assign o_vsync          = vs_q;
  assign o_pattern_active = pat_q;

endmodule

// File: tb/tb_video_pattern_mux.sv
// Directed bench for video_pattern_mux at 1280x720, GRID_LOG2=5.
module tb_video_pattern_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rgb565;
  logic        active;
  logic        hsync;
  logic        vsync;
  logic        fb_ready;
  logic [1:0]  pattern_sel;
  logic [15:0] solid_rgb565;
  logic [23:0] o_rgb888;
  logic        o_active;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_pattern_active;

  int checks = 0;
  int errors = 0;

  logic [23:0] cap_rgb [0:1279];
  logic        cap_pat [0:1279];

  video_pattern_mux #(.H_RES(1280), .V_RES(720), .GRID_LOG2(5)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_rgb565         (rgb565),
    .i_active         (active),
    .i_hsync          (hsync),
    .i_vsync          (vsync),
    .i_fb_ready       (fb_ready),
    .i_pattern_sel    (pattern_sel),
    .i_solid_rgb565   (solid_rgb565),
    .o_rgb888         (o_rgb888),
    .o_active         (o_active),
    .o_hsync          (o_hsync),
    .o_vsync          (o_vsync),
    .o_pattern_active (o_pattern_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vsync_pulse();
    active = 1'b0;
    vsync  = 1'b1;
    step();
    step();
    vsync = 1'b0;
    step();
    step();
  endtask

  // One active line of len pixels, output captured per x; optional drop of
  // fb_ready at pixel drop_at; optional vsync on the first blank cycle.
  task automatic line(input int len, input int drop_at, input bit vs_after);
    for (int x = 0; x < len; x++) begin
      if (x == drop_at) fb_ready = 1'b0;
      active = 1'b1;
      step();
      cap_rgb[x] = o_rgb888;
      cap_pat[x] = o_pattern_active;
    end
    active = 1'b0;
    vsync  = vs_after;
    step();
    hsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
    hsync = 1'b0;
    step();
  endtask

  initial begin
    rst          = 1'b1;
    rgb565       = 16'hF800;
    active       = 1'b0;
    hsync        = 1'b0;
    vsync        = 1'b0;
    fb_ready     = 1'b0;
    pattern_sel  = 2'd0;
    solid_rgb565 = 16'h07E0;

    // Reset state
    step();
    step();
    chk("rst_rgb", o_rgb888, 24'h000000);
    chk("rst_act", o_active, 1'b0);
    chk("rst_hs", o_hsync, 1'b0);
    chk("rst_vs", o_vsync, 1'b0);
    chk("rst_pat", o_pattern_active, 1'b1);
    rst = 1'b0;

    // Uncalibrated, pass-through requested: bars for two frames
    vsync_pulse();
    line(1280, -1, 1'b0);
    vsync_pulse();
    line(1280, -1, 1'b0);
    chk("bars_x0", cap_rgb[0], 24'hF8FCF8);
    chk("bars_x159", cap_rgb[159], 24'hF8FCF8);
    chk("bars_x160", cap_rgb[160], 24'hF8FC00);
    chk("bars_x320", cap_rgb[320], 24'h00FCF8);
    chk("bars_x800", cap_rgb[800], 24'hF80000);
    chk("bars_x1279", cap_rgb[1279], 24'h000000);
    chk("bars_pat", cap_pat[0], 1'b1);

    // Calibration arrives mid-frame: bars until the next vsync
    fb_ready = 1'b1;
    line(64, -1, 1'b0);
    chk("rdy_midframe_x0", cap_rgb[0], 24'hF8FCF8);
    chk("rdy_midframe_pat", cap_pat[0], 1'b1);

    // Sync latency: outputs follow inputs one edge later
    vsync = 1'b1;
    hsync = 1'b1;
    chk("vs_before_edge", o_vsync, 1'b0);
    chk("hs_before_edge", o_hsync, 1'b0);
    step();
    chk("vs_after_edge", o_vsync, 1'b1);
    chk("hs_after_edge", o_hsync, 1'b1);
    chk("blank_rgb_vs", o_rgb888, 24'h000000);
    vsync = 1'b0;
    hsync = 1'b0;
    step();
    chk("vs_fall", o_vsync, 1'b0);
    step();
    active = 1'b1;
    chk("de_before_edge", o_active, 1'b0);
    step();
    chk("de_after_edge", o_active, 1'b1);
    chk("pass_first_pix", o_rgb888, 24'hF80000);
    chk("pass_pat", o_pattern_active, 1'b0);
    active = 1'b0;
    step();
    chk("de_fall", o_active, 1'b0);
    chk("pass_blank", o_rgb888, 24'h000000);
    step();
    line(16, -1, 1'b0);
    chk("pass_x5", cap_rgb[5], 24'hF80000);

    // Grid mode
    pattern_sel = 2'd2;
    vsync_pulse();
    for (int y = 0; y < 34; y++) begin
      line(40, -1, 1'b0);
      if (y == 0) chk("grid_y0_x33", cap_rgb[33], 24'hF8FCF8);
      if (y == 1) begin
        chk("grid_y1_x0", cap_rgb[0], 24'hF8FCF8);
        chk("grid_y1_x1", cap_rgb[1], 24'h000000);
        chk("grid_y1_x32", cap_rgb[32], 24'hF8FCF8);
        chk("grid_y1_x33", cap_rgb[33], 24'h000000);
        chk("grid_pat", cap_pat[1], 1'b1);
      end
      if (y == 32) chk("grid_y32_x33", cap_rgb[33], 24'hF8FCF8);
      if (y == 33) begin
        chk("grid_y33_x33", cap_rgb[33], 24'h000000);
        chk("grid_y33_x32", cap_rgb[32], 24'hF8FCF8);
      end
    end

    // DE fall and vsync rise on the same cycle: y restarts at 0
    line(40, -1, 1'b1);
    chk("grid_y34_x1", cap_rgb[1], 24'h000000);
    line(40, -1, 1'b0);
    chk("simul_y0_x1", cap_rgb[1], 24'hF8FCF8);
    line(40, -1, 1'b0);
    chk("simul_y1_x1", cap_rgb[1], 24'h000000);

    // Calibration lost at line 100 in pass-through
    pattern_sel = 2'd0;
    vsync_pulse();
    for (int l = 0; l < 100; l++) line(8, -1, 1'b0);
    line(8, 3, 1'b0);
    chk("drop_x2_pass", cap_rgb[2], 24'hF80000);
    chk("drop_x2_pat", cap_pat[2], 1'b0);
    chk("drop_x3_bars", cap_rgb[3], 24'hF8FCF8);
    chk("drop_x3_pat", cap_pat[3], 1'b1);
    fb_ready = 1'b1;
    line(8, -1, 1'b0);
    chk("regain_still_bars", cap_rgb[0], 24'hF8FCF8);
    vsync_pulse();
    line(8, -1, 1'b0);
    chk("regain_pass", cap_rgb[0], 24'hF80000);

    // Select change mid-frame waits for vsync
    pattern_sel = 2'd1;
    vsync_pulse();
    line(8, -1, 1'b0);
    chk("sel1_bars", cap_rgb[2], 24'hF8FCF8);
    pattern_sel = 2'd3;
    line(8, -1, 1'b0);
    chk("sel3_ignored", cap_rgb[2], 24'hF8FCF8);
    vsync_pulse();
    line(8, -1, 1'b0);
    chk("solid_x2", cap_rgb[2], 24'h00FC00);
    chk("solid_pat", cap_pat[2], 1'b1);

    // Asynchronous reset mid-line in pass-through
    pattern_sel = 2'd0;
    vsync_pulse();
    active = 1'b1;
    step();
    step();
    chk("pre_rst_pass", o_rgb888, 24'hF80000);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_rgb", o_rgb888, 24'h000000);
    chk("async_rst_act", o_active, 1'b0);
    chk("async_rst_pat", o_pattern_active, 1'b1);
    step();
    rst = 1'b0;
    line(8, -1, 1'b0);
    chk("post_rst_bars", cap_rgb[0], 24'hF8FCF8);
    vsync_pulse();
    line(8, -1, 1'b0);
    chk("post_rst_pass", cap_rgb[0], 24'hF80000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_pattern_mux.md
# video_pattern_mux

Video-path stage between `framebuffer_reader` and `DVI_TX_Top`, in the PSRAM `clk_out` pixel domain. It either passes framebuffer RGB565 pixels through or replaces them with a built-in test pattern: colour bars, grid, or solid colour. It expands the result to RGB888 and keeps DE/HS/VS aligned with a fixed 1-cycle latency. Colour bars are forced while the PSRAM is not calibrated, so the HDMI output shows a valid picture before the framebuffer is usable.

## Interface
Parameters:
- `H_RES`, 1280: active pixels per line; must be divisible by 8.
- `V_RES`, 720: active lines per frame.
- `GRID_LOG2`, 5: grid pitch is 2^GRID_LOG2 pixels.

Ports:
- `i_clk` in 1: pixel clock (PSRAM `clk_out`).
- `i_rst` in 1: asynchronous, active-high reset.
- `i_rgb565` in 16: framebuffer pixel.
- `i_active` in 1: DE from `framebuffer_reader`.
- `i_hsync` in 1: HS, positive polarity.
- `i_vsync` in 1: VS, positive polarity.
- `i_fb_ready` in 1: PSRAM `init_calib`; same clock domain, no synchroniser.
- `i_pattern_sel` in 2: 0 pass-through, 1 colour bars, 2 grid, 3 solid.
- `i_solid_rgb565` in 16: colour for mode 3.
- `o_rgb888` out 24: {R5,000, G6,00, B5,000}, zero-padded.
- `o_active` out 1: DE delayed 1 cycle.
- `o_hsync` out 1: HS delayed 1 cycle.
- `o_vsync` out 1: VS delayed 1 cycle.
- `o_pattern_active` out 1: 1 when the effective mode is not pass-through.

## Operation
- **Position counters.**
  - `x` increments each cycle `i_active`=1 and clears on the `i_active` falling edge.
  - `y` increments on each `i_active` falling edge and clears on the `i_vsync` rising edge.
  - `x` saturates at H_RES-1; `y` saturates at V_RES-1.
- **Bar index.**
  - `bar_idx` (3b) and `bar_cnt` advance without a divider: `bar_cnt` counts 0..H_RES/8-1, then wraps and `bar_idx` increments.
  - `bar_idx` saturates at 7; both clear with `x`.
- **Mode register.**
  - `mode_q` loads on the `i_vsync` rising edge: `i_pattern_sel` if `i_fb_ready`=1, else 1.
  - `i_fb_ready`=0 at any cycle forces the effective mode to 1 immediately, mid-frame included.
  - `i_fb_ready` rising takes effect only at the next vsync rising edge.
  - `i_pattern_sel` changes mid-frame are ignored until the next vsync rising edge.
- **Colour bars** by `bar_idx` 0..7: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- **Grid:** FFFF when `x[GRID_LOG2-1:0]`==0 or `y[GRID_LOG2-1:0]`==0, else 0000.
- **Solid:** `i_solid_rgb565`.
- **Blanking:** when `i_active`=0, the selected pixel is 0000.
- **Edge detection:** uses 1-cycle delayed copies of `i_active` and `i_vsync`. A frame that starts mid-stream after reset counts `y` from 0 until the first vsync.

## Timing
- All outputs are registered, with latency exactly 1 cycle from inputs in every mode.
- `o_active`, `o_hsync` and `o_vsync` are never combinationally derived.
- Reset values:
  - `o_rgb888`=0, `o_active`=0, `o_hsync`=0, `o_vsync`=0.
  - `o_pattern_active`=1, because `mode_q` resets to 1.
  - All counters reset to 0.
- Reset mid-line: outputs go to 0 asynchronously. After release, pass-through is unavailable until a vsync rising edge with `i_fb_ready`=1.
- Simultaneous `i_active` falling edge and `i_vsync` rising edge in the same cycle: vsync wins and `y` clears to 0.

## Configuration
- Macro `VPM_MOVING_BAR_EN`.
- When defined:
  - A 11-bit `bar_ofs` advances by 4 on each vsync rising edge.
  - `bar_ofs` wraps to 0 when `bar_ofs+4 >= H_RES`.
  - In modes 1–3, pixels with `bar_ofs <= x <= bar_ofs+7` are forced to FFFF. This gives a visible frame-advance check.
- When undefined: no offset register and patterns are static. Pass-through is identical either way.

## Structure
- Package `vpm_pkg`:
  - Mode encodings: MODE_PASS, MODE_BARS, MODE_GRID, MODE_SOLID.
  - The eight bar-colour constants.
  - The RGB565→RGB888 expansion function.
- Sub-module `vpm_pos_counter`: edge detection plus the `x`, `y`, `bar_cnt`, `bar_idx` counters.
- The top holds the mode register, pixel mux, optional moving bar, and output registers.

## Test plan
- Reset with `i_fb_ready`=0, run 2 frames with mode 0 → bars output. Pixel x=0 gives `o_rgb888`=F8FCF8; x=160 gives F8FC00; x=1279 gives 000000. `o_pattern_active`=1.
- `i_fb_ready`=1 mid-frame with sel=0, `i_rgb565`=F800 → bars until the next vsync, then `o_rgb888`=F80000. DE/HS/VS are delayed exactly 1 cycle.
- Mode 2, GRID_LOG2=5 → FFFF only at x∈{0,32,…} or y∈{0,32,…}. Pixel (33,33) is black.
- Drop `i_fb_ready` at line 100 in pass-through → bars from the very next cycle.
- Change `i_pattern_sel` 1→3 mid-frame with solid=07E0 → switch occurs on the vsync rising-edge cycle; output 00FC00.
- With `VPM_MOVING_BAR_EN`, mode 3: frame n has a white bar at x=4n..4n+7. At 4n+4 >= 1280 it wraps to x=0..7.
